// File: rtl/gcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gcd_pkg
// Description : Shared constants and FSM state type for the GCD job
//               dispatcher and its input FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package gcd_pkg;

  // Operand/result width of the attached GCD core.
  localparam int unsigned C_W_DEFAULT       = 10;
  // Input FIFO entries (power of two, >= 2).
  localparam int unsigned C_DEPTH_DEFAULT   = 4;
  // Cycles to wait for core done before a job is aborted.
  localparam int unsigned C_TIMEOUT_DEFAULT = 1023;

  // Dispatcher FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/gcd_job_fifo.sv
`default_nettype none
// ============================================================================
// Module      : gcd_job_fifo
// Description : Synchronous FIFO holding operand pairs. Push is refused when
//               full (no full-bypass); push and pop may coincide.
// Revision    : 1.0 - initial release
// ============================================================================
module gcd_job_fifo
  import gcd_pkg::*;
#(
  parameter int unsigned DW    = 2 * C_W_DEFAULT,
  parameter int unsigned DEPTH = C_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_i,
  input  logic [DW-1:0]              wr_data_i,
  input  logic                       rd_en_i,
  output logic [DW-1:0]              rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push;
  logic          pop;

  // Gate requests with the registered flags so a full FIFO never overwrites.
  assign push = wr_en_i && !full_o;
  assign pop  = rd_en_i && !empty_o;

  // Storage array: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;

endmodule
`default_nettype wire

// File: rtl/gcd_job_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : gcd_job_dispatcher
// Description : Buffers operand pairs, issues them one at a time to a GCD
//               core over a start/done handshake, and returns results on a
//               valid/ready stream. Zero operands bypass the core; a job
//               whose done never arrives is aborted after TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module gcd_job_dispatcher
  import gcd_pkg::*;
#(
  parameter int unsigned W       = C_W_DEFAULT,
  parameter int unsigned DEPTH   = C_DEPTH_DEFAULT,
  parameter int unsigned TIMEOUT = C_TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         out_timeout,
  output logic         core_start,
  output logic [W-1:0] core_a,
  output logic [W-1:0] core_b,
  input  logic         core_done,
  input  logic [W-1:0] core_result,
  output logic         busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  // Last counter value before abort: WAIT entry counts as cycle 0.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            core_start_q;
  logic [W-1:0]    core_a_q;
  logic [W-1:0]    core_b_q;
  logic            out_valid_q;
  logic [W-1:0]    out_result_q;
  logic            out_timeout_q;

  logic            fifo_full;
  logic            fifo_empty;
  logic [AW:0]     fifo_count;
  logic [2*W-1:0]  fifo_rd_data;
  logic [W-1:0]    pop_a;
  logic [W-1:0]    pop_b;
  logic            pop;

  assign pop   = (state_q == ST_IDLE) && !fifo_empty;
  assign pop_a = fifo_rd_data[2*W-1:W];
  assign pop_b = fifo_rd_data[W-1:0];

  gcd_job_fifo #(
    .DW    (2 * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (in_valid),
    .wr_data_i ({in_a, in_b}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // Job sequencing FSM with timeout counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      core_start_q  <= 1'b0;
      core_a_q      <= '0;
      core_b_q      <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_timeout_q <= 1'b0;
    end else begin
      core_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            core_a_q <= pop_a;
            core_b_q <= pop_b;
            if ((pop_a == '0) || (pop_b == '0)) begin
              // gcd(x,0) = x and gcd(0,0) = 0, so OR gives the answer.
              out_result_q  <= pop_a | pop_b;
              out_timeout_q <= 1'b0;
              out_valid_q   <= 1'b1;
              state_q       <= ST_HOLD;
            end else begin
              core_start_q <= 1'b1;
              state_q      <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_done) begin
            out_result_q  <= core_result;
            out_timeout_q <= 1'b0;
            out_valid_q   <= 1'b1;
            state_q       <= ST_HOLD;
          end else if (cnt_q == TO_LAST) begin
            out_result_q  <= '0;
            out_timeout_q <= 1'b1;
            out_valid_q   <= 1'b1;
            state_q       <= ST_HOLD;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = !fifo_full;
  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_timeout = out_timeout_q;
  assign core_start  = core_start_q;
  assign core_a      = core_a_q;
  assign core_b      = core_b_q;
  assign busy        = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_gcd_job_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_gcd_job_dispatcher
// Description : Directed bench for gcd_job_dispatcher with a behavioural GCD
//               core that answers 6 cycles after start (or never, on demand).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gcd_job_dispatcher;

  localparam int W       = 10;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_timeout;
  logic         core_start;
  logic [W-1:0] core_a;
  logic [W-1:0] core_b;
  logic         core_done   = 1'b0;
  logic [W-1:0] core_result = '0;
  logic         busy;

  always #5 clk = ~clk;

  gcd_job_dispatcher #(
    .W       (W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_timeout (out_timeout),
    .core_start  (core_start),
    .core_a      (core_a),
    .core_b      (core_b),
    .core_done   (core_done),
    .core_result (core_result),
    .busy        (busy)
  );

  int tests    = 0;
  int fails    = 0;
  int n_start  = 0;
  int stab_err = 0;
  logic         core_hang = 1'b0;
  logic [2:0]   dly = '0;
  logic [W-1:0] ma  = '0;
  logic [W-1:0] mb  = '0;
  logic [W-1:0] got[$];

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] t;
    x = a;
    y = b;
    while (y != '0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Behavioural core: done 6 cycles after start; operands must stay stable.
  always @(posedge clk) begin
    core_done <= 1'b0;
    if (rst) begin
      dly <= '0;
    end else if (core_start) begin
      dly <= 3'd1;
      ma  <= core_a;
      mb  <= core_b;
    end else if (dly != 3'd0) begin
      if (core_a !== ma || core_b !== mb) stab_err <= stab_err + 1;
      if (core_hang) begin
        dly <= '0;
      end else if (dly == 3'd5) begin
        core_done   <= 1'b1;
        core_result <= gcd_ref(ma, mb);
        dly         <= '0;
      end else begin
        dly <= dly + 3'd1;
      end
    end
  end

  // Count start pulses seen by the core.
  always @(posedge clk) begin
    if (!rst && core_start === 1'b1) n_start <= n_start + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int max);
    int i;
    i = 0;
    while (out_valid !== 1'b1 && i < max) begin
      tick();
      i++;
    end
    chk(tag, out_valid, 1);
  endtask

  task automatic collect(input int n, input int max);
    int i;
    got.delete();
    i = 0;
    while (got.size() < n && i < max) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) got.push_back(out_result);
      tick();
      i++;
    end
  endtask

  task automatic chk_got(input string tag, input int k, input logic [W-1:0] exp);
    if (k < got.size()) chk(tag, got[k], exp);
    else chk(tag, 32'hFFFF_FFFF, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int i;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_timeout", out_timeout, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_a", core_a, 0);
    chk("rst_core_b", core_b, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // Single job: start one cycle after pop, result one cycle after done.
    push(10'd15, 10'd5);
    tick();
    chk("t1_start", core_start, 1);
    chk("t1_core_a", core_a, 15);
    chk("t1_core_b", core_b, 5);
    repeat (6) tick();
    chk("t1_not_early", out_valid, 0);
    tick();
    chk("t1_valid", out_valid, 1);
    chk("t1_result", out_result, 5);
    chk("t1_timeout", out_timeout, 0);
    chk("t1_one_start", n_start, 1);
    out_ready = 1'b1;
    tick();
    chk("t1_valid_drop", out_valid, 0);
    out_ready = 1'b0;

    // Back-to-back jobs with the consumer always ready.
    out_ready = 1'b1;
    push(10'd30, 10'd10);
    push(10'd18, 10'd24);
    push(10'd1023, 10'd341);
    collect(3, 200);
    chk("t2_count", got.size(), 3);
    chk_got("t2_r0", 0, 10);
    chk_got("t2_r1", 1, 6);
    chk_got("t2_r2", 2, 341);
    chk("t2_starts", n_start, 4);
    chk("t2_stable", stab_err, 0);
    out_ready = 1'b0;

    // Zero operands bypass the core.
    base = n_start;
    push(10'd0, 10'd7);
    tick();
    chk("t3a_valid", out_valid, 1);
    chk("t3a_result", out_result, 7);
    chk("t3a_timeout", out_timeout, 0);
    out_ready = 1'b1;
    tick();
    chk("t3a_drop", out_valid, 0);
    out_ready = 1'b0;
    push(10'd0, 10'd0);
    tick();
    chk("t3b_valid", out_valid, 1);
    chk("t3b_result", out_result, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_no_start", n_start, base);

    // Backpressure: 4 buffered + 1 in flight/HOLD fills everything.
    push(10'd12, 10'd8);
    push(10'd9, 10'd6);
    push(10'd0, 10'd5);
    push(10'd14, 10'd21);
    chk("t4_ready_before_full", in_ready, 1);
    push(10'd100, 10'd75);
    chk("t4_full", in_ready, 0);
    push(10'd1, 10'd1);
    chk("t4_still_full", in_ready, 0);
    wait_valid("t4_first_valid", 40);
    chk("t4_first_result", out_result, 4);
    repeat (10) tick();
    chk("t4_hold_valid", out_valid, 1);
    chk("t4_hold_result", out_result, 4);
    chk("t4_hold_full", in_ready, 0);
    out_ready = 1'b1;
    collect(5, 300);
    chk("t4_count", got.size(), 5);
    chk_got("t4_r0", 0, 4);
    chk_got("t4_r1", 1, 3);
    chk_got("t4_r2", 2, 5);
    chk_got("t4_r3", 3, 7);
    chk_got("t4_r4", 4, 25);
    repeat (5) tick();
    chk("t4_no_extra", out_valid, 0);
    chk("t4_idle", busy, 0);
    out_ready = 1'b0;

    // Core never answers: abort exactly TIMEOUT cycles after WAIT entry.
    core_hang = 1'b1;
    push(10'd21, 10'd14);
    tick();
    chk("t5_start", core_start, 1);
    tick();
    repeat (TIMEOUT - 1) tick();
    chk("t5_not_early", out_valid, 0);
    tick();
    chk("t5_valid", out_valid, 1);
    chk("t5_timeout", out_timeout, 1);
    chk("t5_result", out_result, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    core_hang = 1'b0;
    push(10'd21, 10'd14);
    wait_valid("t5_next_valid", 40);
    chk("t5_next_result", out_result, 7);
    chk("t5_next_timeout", out_timeout, 0);
    out_ready = 1'b1;
    tick();

    // Reset during WAIT of job 2 of 3.
    base = n_start;
    push(10'd30, 10'd10);
    push(10'd18, 10'd24);
    push(10'd1023, 10'd341);
    i = 0;
    while (n_start < base + 2 && i < 100) begin
      tick();
      i++;
    end
    chk("t6_job2_started", n_start, base + 2);
    tick();
    rst = 1'b1;
    tick();
    chk("t6_out_valid", out_valid, 0);
    chk("t6_core_start", core_start, 0);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_busy", busy, 0);
    chk("t6_out_result", out_result, 0);
    chk("t6_out_timeout", out_timeout, 0);
    chk("t6_core_a", core_a, 0);
    chk("t6_core_b", core_b, 0);
    rst = 1'b0;
    repeat (12) tick();
    chk("t6_no_stale_valid", out_valid, 0);
    chk("t6_no_new_start", n_start, base + 2);
    out_ready = 1'b0;
    push(10'd45, 10'd27);
    wait_valid("t6_after_valid", 40);
    chk("t6_after_result", out_result, 9);
    chk("t6_after_timeout", out_timeout, 0);
    out_ready = 1'b1;
    tick();
    chk("t6_final_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
